call_stack: RTL and testbench

- Hardware LIFO stack that consumes the stack_en / stack_rw / stack_rst controls emitted by the instruction decoder for PSH, POP and STP.
- Stores 16-bit register values written during PSH (EXEC1).
- On POP, returns the top entry on a registered output that is valid in EXEC2, which is when the decoder enables the destination-register write.
- Sits beside the register file; din comes from the s1-selected register bus, and dout feeds the register write-back mux.

---
 rtl/call_stack_pkg.sv | 9 +
 rtl/stack_mem.sv | 25 ++
 rtl/call_stack.sv | 104 ++++++++++
 tb/tb_call_stack.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/call_stack_pkg.sv
// Shared constants for the call stack and the instruction decoder that drives it.
package call_stack_pkg;
    localparam int   DW    = 16;
    localparam int   DEPTH = 16;

    // stack_rw encoding as emitted by the decoder
    localparam logic PUSH  = 1'b1;
    localparam logic POP   = 1'b0;
endpackage

// File: rtl/stack_mem.sv
// DEPTH x DW register array: one synchronous write port, one combinational read port.
module stack_mem
    import call_stack_pkg::*;
#(
    parameter int DW    = call_stack_pkg::DW,
    parameter int DEPTH = call_stack_pkg::DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// LIFO stack for PSH/POP/STP. A contiguous pop run pops once, on its first cycle,
// so dout is valid from the end of EXEC1 through EXEC2.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DW    = call_stack_pkg::DW,
    parameter int DEPTH = call_stack_pkg::DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          stack_en,
    input  logic          stack_rw,
    input  logic          stack_rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   sp,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    logic [AW:0]   sp_q, sp_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          pop_d_q, pop_d_d;

    logic          push_req, pop_req, pop_edge;
    logic          we;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    assign push_req = stack_en & (stack_rw == PUSH);
    assign pop_req  = stack_en & (stack_rw == POP);
    assign pop_edge = pop_req & ~pop_d_q;

    assign empty = (sp_q == '0);
    assign full  = (sp_q == (AW+1)'(DEPTH));
    assign raddr = AW'(sp_q - 1'b1);

    stack_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_i   (CLK),
        .we_i    (we),
        .waddr_i (sp_q[AW-1:0]),
        .wdata_i (din),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        sp_d    = sp_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        pop_d_d = pop_req;
        we      = 1'b0;
        if (stack_rst) begin
            sp_d    = '0;
            dout_d  = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            pop_d_d = 1'b0;
        end else if (push_req) begin
            if (!full) begin
                we   = 1'b1;
                sp_d = sp_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop_edge) begin
            if (!empty) begin
                sp_d   = sp_q - 1'b1;
                dout_d = rdata;
            end else begin
                dout_d = '0;
                udf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp_q    <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            pop_d_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            pop_d_q <= pop_d_d;
        end
    end

    assign dout      = dout_q;
    assign sp        = sp_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed + random bench for call_stack against a queue-based LIFO model.
module tb_call_stack;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK, RST;
    logic          stack_en, stack_rw, stack_rst;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW:0]   sp;
    logic          empty, full, overflow, underflow;

    call_stack #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .stack_en  (stack_en),
        .stack_rw  (stack_rw),
        .stack_rst (stack_rst),
        .din       (din),
        .dout      (dout),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] m_stk[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_udf, m_in_pop;
    int            m_udf_events;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_stk.delete();
        m_dout   = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_in_pop = 1'b0;
    endtask

    // One clock of the stack's documented behaviour
    task automatic m_clock(input logic en, input logic rw, input logic srst, input logic [DW-1:0] d);
        if (srst) begin
            m_reset();
        end else if (en && rw) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(d);
            else m_ovf = 1'b1;
            m_in_pop = 1'b0;
        end else if (en && !rw) begin
            if (!m_in_pop) begin
                if (m_stk.size() > 0) m_dout = m_stk.pop_back();
                else begin
                    m_dout = '0;
                    m_udf  = 1'b1;
                    m_udf_events++;
                end
            end
            m_in_pop = 1'b1;
        end else begin
            m_in_pop = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".sp"}, 32'(sp), 32'(m_stk.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(m_stk.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic step(input string tag, input logic en, input logic rw, input logic srst,
                        input logic [DW-1:0] d);
        stack_en  = en;
        stack_rw  = rw;
        stack_rst = srst;
        din       = d;
        @(posedge CLK);
        #1;
        m_clock(en, rw, srst, d);
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [DW-1:0] d);
        step(tag, 1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // pop run of n cycles followed by an idle cycle that ends the run
    task automatic pop_run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, '0);
        idle(tag);
    endtask

    initial begin
        stack_en = 0; stack_rw = 0; stack_rst = 0; din = '0;
        m_udf_events = 0;
        m_reset();
        RST = 1'b1;
        #12;
        check_all("rst");
        RST = 1'b0;
        for (int i = 0; i < 3; i++) idle("idle");

        // basic LIFO with 2-cycle pop runs
        push("p1", 16'h1111);
        push("p2", 16'h2222);
        push("p3", 16'h3333);
        step("pop3a", 1'b1, 1'b0, 1'b0, '0);
        chk("pop3a.sp_const", 32'(sp), 32'd2);
        chk("pop3a.dout_const", 32'(dout), 32'h3333);
        step("pop3b", 1'b1, 1'b0, 1'b0, '0);
        chk("pop3b.dout_const", 32'(dout), 32'h3333);
        idle("gap");
        pop_run("pop2", 2);
        chk("pop2.dout_const", 32'(dout), 32'h2222);
        chk("pop2.sp_const", 32'(sp), 32'd1);
        pop_run("pop1", 2);

        // fill and overflow
        for (int i = 0; i < DEPTH; i++) push("fill", 16'(i));
        chk("fill.full_const", 32'(full), 32'd1);
        push("ovf", 16'hBEEF);
        chk("ovf.flag_const", 32'(overflow), 32'd1);
        chk("ovf.sp_const", 32'(sp), 32'd16);
        pop_run("ovfpop", 2);
        chk("ovfpop.dout_const", 32'(dout), 32'h000F);
        for (int i = 0; i < 10; i++) pop_run("drain", 2);
        // sp=5, overflow=1: clear with a simultaneous push
        chk("pre_srst.sp_const", 32'(sp), 32'd5);
        step("srst_push", 1'b1, 1'b1, 1'b1, 16'h7777);
        chk("srst.sp_const", 32'(sp), 32'd0);
        chk("srst.ovf_const", 32'(overflow), 32'd0);

        // underflow from empty: one event per run
        m_udf_events = 0;
        pop_run("udf", 2);
        chk("udf.flag_const", 32'(underflow), 32'd1);
        chk("udf.events", 32'(m_udf_events), 32'd1);
        step("udf_clr", 1'b0, 1'b0, 1'b1, '0);

        // push then pop, pop/push/pop back-to-back
        push("a5", 16'hA5A5);
        step("a5pop", 1'b1, 1'b0, 1'b0, '0);
        chk("a5pop.dout_const", 32'(dout), 32'hA5A5);
        push("mid", 16'h5A5A);
        step("newedge", 1'b1, 1'b0, 1'b0, '0);
        chk("newedge.dout_const", 32'(dout), 32'h5A5A);
        idle("gap2");

        // async RST mid pop run
        push("ar1", 16'h1234);
        push("ar2", 16'h4321);
        step("arpop", 1'b1, 1'b0, 1'b0, '0);
        #2;
        RST = 1'b1;
        #1;
        m_reset();
        check_all("async_rst");
        #1;
        RST = 1'b0;
        step("arpop_after", 1'b1, 1'b0, 1'b0, '0);
        chk("arpop_after.udf_const", 32'(underflow), 32'd1);
        idle("gap3");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic en, rw, sr;
            en = ($urandom_range(0, 9) < 8);
            rw = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35));
            sr = ($urandom_range(0, 59) == 0);
            step("rnd", en, rw, sr, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
